// File: rtl/aq_djpeg_fbwrite.sv
// Pixel-to-framebuffer writer for the JPEG decoder pixel stream.
// Each accepted pixel becomes a 32-bit write {8'h00,R,G,B} at Base + Y*Stride + X*4,
// buffered in a show-ahead FIFO because the decoder output cannot be stalled.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   Start, BaseAddr, Stride           frame start pulse and latched geometry
//   DecodeIdle                        decoder idle flag (ends the frame)
//   InEnable, InPixelX/Y, InR/G/B     decoder pixel stream
//   WrValid, WrReady, WrAddr, WrData  memory write handshake
//   Busy, FrameDone, Overflow, PixelCount  status
module aq_djpeg_fbwrite #(
    parameter int unsigned FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [31:0] BaseAddr,
    input  logic [15:0] Stride,
    input  logic        DecodeIdle,
    input  logic        InEnable,
    input  logic [15:0] InPixelX,
    input  logic [15:0] InPixelY,
    input  logic [7:0]  InR,
    input  logic [7:0]  InG,
    input  logic [7:0]  InB,
    output logic        WrValid,
    input  logic        WrReady,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        Busy,
    output logic        FrameDone,
    output logic        Overflow,
    output logic [31:0] PixelCount
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

    state_e              state_q, state_d;
    logic                seen_run_q, seen_run_d;
    logic [31:0]         base_q, base_d;
    logic [15:0]         stride_q, stride_d;
    logic                s1_valid_q, s1_valid_d;
    logic [15:0]         s1_x_q, s1_x_d;
    logic [15:0]         s1_y_q, s1_y_d;
    logic [23:0]         s1_rgb_q, s1_rgb_d;
    logic                s2_valid_q, s2_valid_d;
    logic [31:0]         s2_addr_q, s2_addr_d;
    logic [31:0]         s2_data_q, s2_data_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                wr_valid_q, wr_valid_d;
    logic [31:0]         wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         pixel_count_q, pixel_count_d;
    logic [63:0]         mem_q [DEPTH];

    logic                pop, full, push_ok, drop;
    logic [63:0]         head;

    // State, pipeline, FIFO control and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            seen_run_q    <= 1'b0;
            base_q        <= '0;
            stride_q      <= '0;
            s1_valid_q    <= 1'b0;
            s1_x_q        <= '0;
            s1_y_q        <= '0;
            s1_rgb_q      <= '0;
            s2_valid_q    <= 1'b0;
            s2_addr_q     <= '0;
            s2_data_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            pixel_count_q <= '0;
        end else begin
            state_q       <= state_d;
            seen_run_q    <= seen_run_d;
            base_q        <= base_d;
            stride_q      <= stride_d;
            s1_valid_q    <= s1_valid_d;
            s1_x_q        <= s1_x_d;
            s1_y_q        <= s1_y_d;
            s1_rgb_q      <= s1_rgb_d;
            s2_valid_q    <= s2_valid_d;
            s2_addr_q     <= s2_addr_d;
            s2_data_q     <= s2_data_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            pixel_count_q <= pixel_count_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {s2_addr_q, s2_data_q};
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        seen_run_d    = seen_run_q;
        base_d        = base_q;
        stride_d      = stride_q;
        s1_valid_d    = 1'b0;
        s1_x_d        = s1_x_q;
        s1_y_d        = s1_y_q;
        s1_rgb_d      = s1_rgb_q;
        s2_valid_d    = s1_valid_q;
        s2_addr_d     = s2_addr_q;
        s2_data_d     = s2_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q;
        pixel_count_d = pixel_count_q;
        head          = '0;

        pop     = wr_valid_q && WrReady;
        full    = (count_q == CW'(DEPTH));
        push_ok = s2_valid_q && (!full || pop);
        drop    = s2_valid_q && full && !pop;

        // S1: capture pixels only while running
        if (InEnable && state_q == ST_RUN) begin
            s1_valid_d = 1'b1;
            s1_x_d     = InPixelX;
            s1_y_d     = InPixelY;
            s1_rgb_d   = {InR, InG, InB};
        end

        // S2: address generation, all arithmetic modulo 2^32
        if (s1_valid_q) begin
            s2_addr_d = base_q + (32'(s1_y_q) * 32'(stride_q)) + {14'b0, s1_x_q, 2'b00};
            s2_data_d = {8'h00, s1_rgb_q};
        end

        // FIFO pointer and occupancy update
        if (push_ok) begin
            wr_ptr_d      = wr_ptr_q + FIFO_AW'(1);
            pixel_count_d = pixel_count_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (drop) begin
            overflow_d = 1'b1;
        end

        // Registered show-ahead head: bypass the entry being written into the head slot
        wr_valid_d = (count_d != '0);
        if (wr_valid_d) begin
            if (push_ok && wr_ptr_q == rd_ptr_d) begin
                head = {s2_addr_q, s2_data_q};
            end else begin
                head = mem_q[rd_ptr_d];
            end
            wr_addr_d = head[63:32];
            wr_data_d = head[31:0];
        end

        // Frame control
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d       = ST_RUN;
                    base_d        = BaseAddr;
                    stride_d      = Stride;
                    overflow_d    = 1'b0;
                    pixel_count_d = '0;
                    seen_run_d    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!DecodeIdle) begin
                    seen_run_d = 1'b1;
                end
                if (seen_run_q && DecodeIdle) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q && count_q == '0 && !wr_valid_q) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign WrValid    = wr_valid_q;
    assign WrAddr     = wr_addr_q;
    assign WrData     = wr_data_q;
    assign Busy       = busy_q;
    assign FrameDone  = frame_done_q;
    assign Overflow   = overflow_q;
    assign PixelCount = pixel_count_q;

endmodule
